issue_queue_add: RTL and testbench

Reservation station for the ADD pipe. It sits directly upstream of the back end and accepts up to three renamed micro-ops per cycle from the dispatch slots x/y/z. It tracks source-operand readiness by snooping the add and mul result broadcasts. Each cycle it issues the oldest fully-ready entry on the valid_add/Pa_add/Pb_add/Pw_add/tag_ROB_add interface, which feeds the PRF read and the READ/EX register.

---
 rtl/issue_queue_add.sv | 173 +++++++++++++++++
 tb/tb_issue_queue_add.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_add.sv
// issue_queue_add: reservation station for the ADD pipe.
//
// Collapsing queue of DEPTH entries, entry 0 oldest. Up to three renamed ops
// per cycle are appended from dispatch slots x/y/z in program order. Source
// readiness is tracked by snooping the add and mul result broadcasts. Each
// cycle the oldest fully-ready entry is presented on the *_add issue port and
// removed on the edge it is issued.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               discard all entries
//   freeze_front        dispatch stalled, nothing accepted
//   freeze_back         downstream stalled, nothing issued
//   valid_dispatch_*, Pa_*, Pb_*, Pw_*, tag_ROB_*, rdyA_*, rdyB_*
//                       dispatch slots x/y/z
//   valid_Result_add/mul, Pw_Result_add/mul
//                       wakeup broadcasts
//   full_RS             fewer than three free entries
//   valid_add, Pa_add, Pb_add, Pw_add, tag_ROB_add
//                       issued op (data zero when valid_add=0)
module issue_queue_add #(
    parameter int DEPTH = 8,
    parameter int P_W   = 5,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             freeze_front,
    input  logic             freeze_back,
    input  logic             valid_dispatch_x,
    input  logic             valid_dispatch_y,
    input  logic             valid_dispatch_z,
    input  logic [P_W-1:0]   Pa_x,
    input  logic [P_W-1:0]   Pa_y,
    input  logic [P_W-1:0]   Pa_z,
    input  logic [P_W-1:0]   Pb_x,
    input  logic [P_W-1:0]   Pb_y,
    input  logic [P_W-1:0]   Pb_z,
    input  logic [P_W-1:0]   Pw_x,
    input  logic [P_W-1:0]   Pw_y,
    input  logic [P_W-1:0]   Pw_z,
    input  logic [TAG_W-1:0] tag_ROB_x,
    input  logic [TAG_W-1:0] tag_ROB_y,
    input  logic [TAG_W-1:0] tag_ROB_z,
    input  logic             rdyA_x,
    input  logic             rdyA_y,
    input  logic             rdyA_z,
    input  logic             rdyB_x,
    input  logic             rdyB_y,
    input  logic             rdyB_z,
    input  logic             valid_Result_add,
    input  logic [P_W-1:0]   Pw_Result_add,
    input  logic             valid_Result_mul,
    input  logic [P_W-1:0]   Pw_Result_mul,
    output logic             full_RS,
    output logic             valid_add,
    output logic [P_W-1:0]   Pa_add,
    output logic [P_W-1:0]   Pb_add,
    output logic [P_W-1:0]   Pw_add,
    output logic [TAG_W-1:0] tag_ROB_add
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic             valid;
        logic [P_W-1:0]   pa;
        logic             rdya;
        logic [P_W-1:0]   pb;
        logic             rdyb;
        logic [P_W-1:0]   pw;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t          q    [DEPTH];
    entry_t          q_n  [DEPTH];
    entry_t          slot [3];
    logic [CW-1:0]   pos  [3];
    logic [CW-1:0]   count, count_n, base;
    logic            sel_found, issue, accept;
    logic [IW-1:0]   sel_idx;
    entry_t          sel_e;

    // True when tag p matches either result broadcast this cycle.
    function automatic logic woken(input logic [P_W-1:0] p,
                                   input logic va, input logic [P_W-1:0] pwa,
                                   input logic vm, input logic [P_W-1:0] pwm);
        return (va && (p == pwa)) || (vm && (p == pwm));
    endfunction

    assign full_RS = count > CW'(DEPTH - 3);
    assign accept  = !freeze_front && !full_RS && !flush && !rst;

    // Oldest ready entry: scan from the top so the lowest index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (q[i].valid && q[i].rdya && q[i].rdyb) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign issue       = sel_found && !freeze_back && !flush && !rst;
    assign sel_e       = issue ? q[sel_idx] : '0;
    assign valid_add   = issue;
    assign Pa_add      = sel_e.pa;
    assign Pb_add      = sel_e.pb;
    assign Pw_add      = sel_e.pw;
    assign tag_ROB_add = sel_e.tag;

    // Incoming ops, with same-cycle broadcast bypass on the ready bits.
    always_comb begin
        slot[0] = '{valid_dispatch_x, Pa_x,
                    rdyA_x | woken(Pa_x, valid_Result_add, Pw_Result_add, valid_Result_mul, Pw_Result_mul),
                    Pb_x,
                    rdyB_x | woken(Pb_x, valid_Result_add, Pw_Result_add, valid_Result_mul, Pw_Result_mul),
                    Pw_x, tag_ROB_x};
        slot[1] = '{valid_dispatch_y, Pa_y,
                    rdyA_y | woken(Pa_y, valid_Result_add, Pw_Result_add, valid_Result_mul, Pw_Result_mul),
                    Pb_y,
                    rdyB_y | woken(Pb_y, valid_Result_add, Pw_Result_add, valid_Result_mul, Pw_Result_mul),
                    Pw_y, tag_ROB_y};
        slot[2] = '{valid_dispatch_z, Pa_z,
                    rdyA_z | woken(Pa_z, valid_Result_add, Pw_Result_add, valid_Result_mul, Pw_Result_mul),
                    Pb_z,
                    rdyB_z | woken(Pb_z, valid_Result_add, Pw_Result_add, valid_Result_mul, Pw_Result_mul),
                    Pw_z, tag_ROB_z};
    end

    // Appended ops go right after the survivors; invalid slots take no room.
    assign base   = count - CW'(issue);
    assign pos[0] = base;
    assign pos[1] = base + CW'(valid_dispatch_x);
    assign pos[2] = base + CW'(valid_dispatch_x) + CW'(valid_dispatch_y);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            // Collapse over the issued entry; the top slot refills empty.
            if (issue && (i >= int'(sel_idx))) begin
                q_n[i] = (i == DEPTH - 1) ? '0 : q[(i + 1) % DEPTH];
            end else begin
                q_n[i] = q[i];
            end
            q_n[i].rdya = q_n[i].rdya |
                woken(q_n[i].pa, valid_Result_add, Pw_Result_add, valid_Result_mul, Pw_Result_mul);
            q_n[i].rdyb = q_n[i].rdyb |
                woken(q_n[i].pb, valid_Result_add, Pw_Result_add, valid_Result_mul, Pw_Result_mul);
            for (int k = 0; k < 3; k++) begin
                if (accept && slot[k].valid && (pos[k] == CW'(i))) q_n[i] = slot[k];
            end
        end
        count_n = base;
        if (accept) begin
            count_n = base + CW'(valid_dispatch_x) + CW'(valid_dispatch_y) + CW'(valid_dispatch_z);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            count <= count_n;
            for (int i = 0; i < DEPTH; i++) q[i] <= q_n[i];
        end
    end

endmodule

// File: tb/tb_issue_queue_add.sv
// Testbench for issue_queue_add: directed steps followed by randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_issue_queue_add;

    localparam int DEPTH = 8;
    localparam int P_W   = 5;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, flush, freeze_front, freeze_back;
    logic             vdx, vdy, vdz;
    logic [P_W-1:0]   Pa_x, Pa_y, Pa_z, Pb_x, Pb_y, Pb_z, Pw_x, Pw_y, Pw_z;
    logic [TAG_W-1:0] tag_x, tag_y, tag_z;
    logic             rdyA_x, rdyA_y, rdyA_z, rdyB_x, rdyB_y, rdyB_z;
    logic             vra, vrm;
    logic [P_W-1:0]   pwra, pwrm;
    logic             full_RS, valid_add;
    logic [P_W-1:0]   Pa_add, Pb_add, Pw_add;
    logic [TAG_W-1:0] tag_ROB_add;

    issue_queue_add #(.DEPTH(DEPTH), .P_W(P_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .freeze_front(freeze_front), .freeze_back(freeze_back),
        .valid_dispatch_x(vdx), .valid_dispatch_y(vdy), .valid_dispatch_z(vdz),
        .Pa_x(Pa_x), .Pa_y(Pa_y), .Pa_z(Pa_z),
        .Pb_x(Pb_x), .Pb_y(Pb_y), .Pb_z(Pb_z),
        .Pw_x(Pw_x), .Pw_y(Pw_y), .Pw_z(Pw_z),
        .tag_ROB_x(tag_x), .tag_ROB_y(tag_y), .tag_ROB_z(tag_z),
        .rdyA_x(rdyA_x), .rdyA_y(rdyA_y), .rdyA_z(rdyA_z),
        .rdyB_x(rdyB_x), .rdyB_y(rdyB_y), .rdyB_z(rdyB_z),
        .valid_Result_add(vra), .Pw_Result_add(pwra),
        .valid_Result_mul(vrm), .Pw_Result_mul(pwrm),
        .full_RS(full_RS), .valid_add(valid_add),
        .Pa_add(Pa_add), .Pb_add(Pb_add), .Pw_add(Pw_add), .tag_ROB_add(tag_ROB_add)
    );

    typedef struct {
        logic [P_W-1:0]   pa, pb, pw;
        logic             ra, rb;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t mq[$];   // reference queue, index 0 oldest
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic woke(input logic [P_W-1:0] p);
        return (vra && p == pwra) || (vrm && p == pwrm);
    endfunction

    function automatic ent_t mk(input logic [P_W-1:0] pa, input logic ra,
                                input logic [P_W-1:0] pb, input logic rb,
                                input logic [P_W-1:0] pw, input logic [TAG_W-1:0] tag);
        ent_t e;
        e.pa = pa; e.pb = pb; e.pw = pw; e.tag = tag;
        e.ra = ra || woke(pa);
        e.rb = rb || woke(pb);
        return e;
    endfunction

    task automatic clr();
        vdx = 0; vdy = 0; vdz = 0; vra = 0; vrm = 0; pwra = '0; pwrm = '0;
        flush = 0; freeze_front = 0; freeze_back = 0;
    endtask

    task automatic disp(input int s, input int pa, input logic ra, input int pb,
                        input logic rb, input int pw, input int tag);
        case (s)
            0: begin vdx = 1; Pa_x = P_W'(pa); rdyA_x = ra; Pb_x = P_W'(pb); rdyB_x = rb;
                     Pw_x = P_W'(pw); tag_x = TAG_W'(tag); end
            1: begin vdy = 1; Pa_y = P_W'(pa); rdyA_y = ra; Pb_y = P_W'(pb); rdyB_y = rb;
                     Pw_y = P_W'(pw); tag_y = TAG_W'(tag); end
            default: begin vdz = 1; Pa_z = P_W'(pa); rdyA_z = ra; Pb_z = P_W'(pb); rdyB_z = rb;
                     Pw_z = P_W'(pw); tag_z = TAG_W'(tag); end
        endcase
    endtask

    // Check outputs against the model, clock one edge, advance the model.
    task automatic tick();
        int   sel;
        logic ev, full;
        ent_t e;
        #1;
        sel = -1;
        foreach (mq[i]) if (sel < 0 && mq[i].ra && mq[i].rb) sel = i;
        ev   = (sel >= 0) && !freeze_back && !flush && !rst;
        full = mq.size() > DEPTH - 3;
        e    = '{default: '0};
        if (ev) e = mq[sel];
        chk("valid_add", 32'(valid_add), 32'(ev));
        chk("Pa_add", 32'(Pa_add), 32'(e.pa));
        chk("Pb_add", 32'(Pb_add), 32'(e.pb));
        chk("Pw_add", 32'(Pw_add), 32'(e.pw));
        chk("tag_ROB_add", 32'(tag_ROB_add), 32'(e.tag));
        chk("full_RS", 32'(full_RS), 32'(full));
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (ev) mq.delete(sel);
            foreach (mq[i]) begin
                if (woke(mq[i].pa)) mq[i].ra = 1'b1;
                if (woke(mq[i].pb)) mq[i].rb = 1'b1;
            end
            if (!freeze_front && !full) begin
                if (vdx) mq.push_back(mk(Pa_x, rdyA_x, Pb_x, rdyB_x, Pw_x, tag_x));
                if (vdy) mq.push_back(mk(Pa_y, rdyA_y, Pb_y, rdyB_y, Pw_y, tag_y));
                if (vdz) mq.push_back(mk(Pa_z, rdyA_z, Pb_z, rdyB_z, Pw_z, tag_z));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        clr();
        rst = 1;
        {Pa_x, Pa_y, Pa_z, Pb_x, Pb_y, Pb_z, Pw_x, Pw_y, Pw_z} = '0;
        {tag_x, tag_y, tag_z} = '0;
        {rdyA_x, rdyA_y, rdyA_z, rdyB_x, rdyB_y, rdyB_z} = '0;
        @(negedge clk);

        // Reset held with a dispatch request present.
        disp(0, 1, 1, 2, 1, 3, 9);
        tick(); tick();
        rst = 0; clr();
        tick(); tick();

        // In-order issue of three ready ops.
        disp(0, 1, 1, 2, 1, 10, 1);
        disp(1, 3, 1, 4, 1, 11, 2);
        disp(2, 5, 1, 6, 1, 12, 3);
        tick();
        clr();
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("inorder_valid", 32'(valid_add), 32'd1);
            chk("inorder_tag", 32'(tag_ROB_add), 32'(k));
            tick();
        end
        #1 chk("inorder_drained", 32'(valid_add), 32'd0);

        // Older op waits on A; younger ready op overtakes it.
        disp(0, 7, 0, 3, 1, 13, 4);
        tick();
        clr();
        disp(0, 1, 1, 2, 1, 14, 5);
        tick();
        clr();
        #1 chk("overtake_tag", 32'(tag_ROB_add), 32'd5);
        tick();
        #1 chk("wait_idle", 32'(valid_add), 32'd0);
        vrm = 1; pwrm = 5'd7;
        #1 chk("wake_same_cycle", 32'(valid_add), 32'd0);
        tick();
        clr();
        #1 chk("wake_valid", 32'(valid_add), 32'd1);
        chk("wake_tag", 32'(tag_ROB_add), 32'd4);
        tick();

        // Dispatch-cycle bypass on B.
        disp(0, 2, 1, 9, 0, 15, 6);
        vra = 1; pwra = 5'd9;
        tick();
        clr();
        #1 chk("bypass_valid", 32'(valid_add), 32'd1);
        chk("bypass_tag", 32'(tag_ROB_add), 32'd6);
        tick();

        // Fill to six non-ready entries, then an ignored dispatch.
        for (int g = 0; g < 2; g++) begin
            for (int s = 0; s < 3; s++) disp(s, 20 + 3*g + s, 0, 1, 1, 16 + s, 7 + 3*g + s);
            tick();
            clr();
        end
        #1 chk("full_at_6", 32'(full_RS), 32'd1);
        for (int s = 0; s < 3; s++) disp(s, 1, 1, 1, 1, 2, 13 + s);
        tick();
        clr();
        #1 chk("full_ignored", 32'(full_RS), 32'd1);
        chk("full_ignored_idle", 32'(valid_add), 32'd0);
        vra = 1; pwra = 5'd20;
        tick();
        clr();
        #1 chk("full_wake_tag", 32'(tag_ROB_add), 32'd7);
        tick();
        #1 chk("full_released", 32'(full_RS), 32'd0);
        flush = 1;
        tick();
        clr();

        // freeze_back holds issue; flush empties the queue.
        for (int s = 0; s < 3; s++) disp(s, 1, 1, 2, 1, 3 + s, 1 + s);
        tick();
        clr();
        freeze_back = 1;
        #1 chk("freeze_idle", 32'(valid_add), 32'd0);
        tick(); tick();
        freeze_back = 0; flush = 1;
        #1 chk("flush_idle", 32'(valid_add), 32'd0);
        tick();
        clr();
        #1 chk("post_flush_idle", 32'(valid_add), 32'd0);
        tick(); tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 500; c++) begin
            logic legal;
            clr();
            rst          = ($urandom_range(0, 99) == 0);
            flush        = ($urandom_range(0, 49) == 0);
            freeze_front = ($urandom_range(0, 7) == 0);
            freeze_back  = ($urandom_range(0, 5) == 0);
            legal = !(mq.size() > DEPTH - 3) && !freeze_front;
            if (legal || $urandom_range(0, 9) == 0) begin
                for (int s = 0; s < 3; s++) begin
                    if ($urandom_range(0, 1) == 1)
                        disp(s, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                             int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
                end
            end
            vra  = ($urandom_range(0, 2) == 0);
            pwra = P_W'($urandom_range(0, 7));
            vrm  = ($urandom_range(0, 2) == 0);
            pwrm = P_W'($urandom_range(0, 7));
            tick();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
